// File: rtl/morse_keyer_pkg.sv
// Shared constants for the Morse transmit keyer: symbol codes, FSM encoding
// and the BCD unit width the timing configuration is built from.
package morse_keyer_pkg;

    localparam int UNIT_BCD_W = 6;

    localparam logic [1:0] SYM_DIT  = 2'b00;
    localparam logic [1:0] SYM_DAH  = 2'b01;
    localparam logic [1:0] SYM_CHAR = 2'b10;
    localparam logic [1:0] SYM_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler (0..p-1) plus unit counter (0..n-1); done marks the last cycle of
// an n-unit phase. p and n must be at least 1.
module morse_unit_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [W-1:0] p,
    input  logic [W-1:0] n,
    output logic         unit_tick,
    output logic         done
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] presc;
    logic [W-1:0] units;

    assign unit_tick = (presc == p - ONE);
    assign done      = unit_tick && (units == n - ONE);

    // The unit counter holds on its last value so it never wraps inside a phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            units <= '0;
        end else if (clear) begin
            presc <= '0;
            units <= '0;
        end else if (unit_tick) begin
            presc <= '0;
            if (!done) units <= units + ONE;
        end else begin
            presc <= presc + ONE;
        end
    end

endmodule

// File: rtl/morse_keyer.sv
// Morse transmit keyer: turns dit/dah/char-gap/word-gap symbols into a keyed
// output. Optional sidetone output enabled by MORSE_SIDETONE_EN.
//
// Handshake: a symbol transfers on a clock edge where sym_valid & sym_ready;
// sym_ready does not depend on sym_valid, and sym_code may change freely while
// sym_ready is low.
module morse_keyer
    import morse_keyer_pkg::*;
#(
    parameter int W        = UNIT_BCD_W * 4,
    parameter int TONE_DIV = 25000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] dit_units,
    input  logic [W-1:0] dah_units,
    input  logic [W-1:0] pause_units,
    input  logic [W-1:0] char_units,
    input  logic [W-1:0] word_units,
    input  logic [W-1:0] pulses_per_unit,
    input  logic         sym_valid,
    input  logic [1:0]   sym_code,
    output logic         sym_ready,
    output logic         key_out,
    output logic         busy
`ifdef MORSE_SIDETONE_EN
    ,
    output logic         tone_out
`endif
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    if (TONE_DIV < 1) begin : g_tone_div_check
        $error("TONE_DIV must be at least 1");
    end

    function automatic logic [W-1:0] eff(input logic [W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    state_t       state, next_state;
    logic [W-1:0] mark_n, pause_n, gap_e, ppu_l;
    logic [W-1:0] timer_n;
    logic         t_tick, t_done, phase_done, accept, timer_clear;
    logic [W-1:0] gap_src;

    assign busy        = (state != ST_IDLE);
    assign phase_done  = (state == ST_GAP && gap_e == '0) ? 1'b1 : (t_tick & t_done);
    assign sym_ready   = (state == ST_IDLE) ||
                         ((state == ST_SPACE || state == ST_GAP) && phase_done);
    assign accept      = sym_valid & sym_ready;
    assign timer_clear = accept || (next_state != state) || (state == ST_IDLE);
    assign gap_src     = (sym_code == SYM_WORD) ? eff(word_units) : eff(char_units);

    always_comb begin
        timer_n = ONE;
        case (state)
            ST_MARK:  timer_n = mark_n;
            ST_SPACE: timer_n = pause_n;
            ST_GAP:   timer_n = (gap_e == '0) ? ONE : gap_e;
            default:  timer_n = ONE;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = sym_code[1] ? ST_GAP : ST_MARK;
            ST_MARK:  if (phase_done) next_state = ST_SPACE;
            ST_SPACE, ST_GAP: begin
                if (phase_done) begin
                    if (accept) next_state = sym_code[1] ? ST_GAP : ST_MARK;
                    else        next_state = ST_IDLE;
                end
            end
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            key_out <= 1'b0;
        end else begin
            state   <= next_state;
            key_out <= (next_state == ST_MARK);
        end
    end

    // Timing is captured once per symbol; the gap excess already discounts the
    // preceding element's space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mark_n  <= '0;
            pause_n <= '0;
            gap_e   <= '0;
            ppu_l   <= '0;
        end else if (accept) begin
            mark_n  <= (sym_code == SYM_DAH) ? eff(dah_units) : eff(dit_units);
            pause_n <= eff(pause_units);
            gap_e   <= (gap_src > eff(pause_units)) ? gap_src - eff(pause_units) : '0;
            ppu_l   <= eff(pulses_per_unit);
        end
    end

    morse_unit_timer #(.W(W)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .p         (ppu_l),
        .n         (timer_n),
        .unit_tick (t_tick),
        .done      (t_done)
    );

`ifdef MORSE_SIDETONE_EN
    localparam logic [31:0] TONE_LAST = TONE_DIV - 1;
    logic [31:0] tone_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            tone_out <= 1'b0;
        end else if (!key_out) begin
            tone_cnt <= '0;
            tone_out <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_out <= ~tone_out;
        end else begin
            tone_cnt <= tone_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: a model predicts mark lengths and the
// low spans between marks; a monitor measures key_out and compares.
module tb_morse_keyer;

    localparam int W = 24;
    localparam logic [1:0] DIT = 2'b00, DAH = 2'b01, CHR = 2'b10, WRD = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] dit_units, dah_units, pause_units, char_units, word_units, ppu;
    logic         sym_valid;
    logic [1:0]   sym_code;
    logic         sym_ready, key_out, busy;
    logic         tone_out;

    always #5 clk = ~clk;

    morse_keyer #(.W(W), .TONE_DIV(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dit_units       (dit_units),
        .dah_units       (dah_units),
        .pause_units     (pause_units),
        .char_units      (char_units),
        .word_units      (word_units),
        .pulses_per_unit (ppu),
        .sym_valid       (sym_valid),
        .sym_code        (sym_code),
        .sym_ready       (sym_ready),
        .key_out         (key_out),
        .busy            (busy)
`ifdef MORSE_SIDETONE_EN
        ,
        .tone_out        (tone_out)
`endif
    );

`ifndef MORSE_SIDETONE_EN
    assign tone_out = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard queues and model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] low_q[$];
    logic [W-1:0] pend;
    bit           have_mark;

    function automatic logic [W-1:0] eff(input logic [W-1:0] v);
        return (v == '0) ? 1 : v;
    endfunction

    // Monitor
    bit mon_en = 0;
    bit prev_key, seen_fall, prev_tone;
    int hi_run, lo_run, tone_toggles, tone_bad;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_key = 0; seen_fall = 0; prev_tone = 0;
            hi_run = 0; lo_run = 0; tone_toggles = 0;
        end else begin
            if (key_out) begin
                if (!prev_key) begin
                    if (seen_fall) begin
                        if (low_q.size() > 0) check_eq("low_span", lo_run, low_q.pop_front());
                        else check_eq("low_unexpected", lo_run, 0);
                    end
                    hi_run = 0;
                end
                hi_run++;
                if (prev_key && tone_out != prev_tone) tone_toggles++;
            end else begin
                if (prev_key) begin
                    if (exp_q.size() > 0) check_eq("mark_len", hi_run, exp_q.pop_front());
                    else check_eq("mark_unexpected", hi_run, 0);
                    seen_fall = 1;
                    lo_run = 0;
                end
                lo_run++;
            end
            prev_key  = key_out;
            prev_tone = tone_out;
        end
        if (!key_out && tone_out) tone_bad++;
    end

    task automatic arm();
        mon_en = 0;
        @(negedge clk);
        @(negedge clk);
        pend = 0;
        have_mark = 0;
        mon_en = 1;
    endtask

    // Offer one symbol (called at a negedge); returns at the negedge after the accept.
    task automatic send(input logic [1:0] c, input bit track);
        logic [W-1:0] p, cw, e;
        int n;
        p = eff(ppu);
        if (track) begin
            if (!c[1]) begin
                if (have_mark) low_q.push_back(pend);
                exp_q.push_back(((c == DAH) ? eff(dah_units) : eff(dit_units)) * p);
                pend = eff(pause_units) * p;
                have_mark = 1;
            end else begin
                cw = (c == WRD) ? eff(word_units) : eff(char_units);
                e = (cw > eff(pause_units)) ? cw - eff(pause_units) : 0;
                pend = pend + ((e == 0) ? 1 : e * p);
            end
        end
        sym_code  = c;
        sym_valid = 1;
        n = 0;
        while (!sym_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!sym_ready) begin
            check_eq("ready_timeout", 0, 1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        sym_valid = 0;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_eq("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_exp_q_empty"}, exp_q.size(), 0);
        check_eq({tag, "_low_q_empty"}, low_q.size(), 0);
        exp_q.delete();
        low_q.delete();
    endtask

    task automatic cfg_default();
        dit_units = 2; dah_units = 6; pause_units = 2;
        char_units = 6; word_units = 14; ppu = 1;
    endtask

    initial begin
        int highs;
        cfg_default();
        sym_valid = 0;
        sym_code  = DIT;
        tone_bad  = 0;
        rst_n = 1;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_key", key_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", sym_ready, 1);
        check_eq("rst_tone", tone_out, 0);
        rst_n = 1;
        @(negedge clk);

        // Single dit with cycle-exact timing
        arm();
        send(DIT, 1);
        sym_valid = 0;
        check_eq("t1_key_c1", key_out, 1);
        @(negedge clk); check_eq("t1_key_c2", key_out, 1);
        @(negedge clk); check_eq("t1_key_c3", key_out, 0);
        check_eq("t1_ready_c3", sym_ready, 0);
        @(negedge clk); check_eq("t1_key_c4", key_out, 0);
        check_eq("t1_ready_c4", sym_ready, 1);
        check_eq("t1_busy_c4", busy, 1);
        @(negedge clk); check_eq("t1_busy_c5", busy, 0);
        wait_idle();
        check_drained("t1");

        // Streamed dit, dah, char gap, dit
        arm();
        send(DIT, 1);
        send(DAH, 1);
        send(CHR, 1);
        send(DIT, 1);
        wait_idle();
        check_drained("t2");

        // P = 3 dah; config change mid-mark must not shorten it
        ppu = 3;
        arm();
        send(DAH, 1);
        sym_valid = 0;
        @(negedge clk);
        dah_units = 1;
        wait_idle();
`ifdef MORSE_SIDETONE_EN
        check_eq("t3_tone_toggles", tone_toggles, 8);
`endif
        check_drained("t3");
        cfg_default();

        // Word gap with E saturating to 0: GAP lasts one cycle
        word_units = 1;
        arm();
        send(WRD, 1);
        sym_valid = 0;
        check_eq("t4_busy_c1", busy, 1);
        check_eq("t4_ready_c1", sym_ready, 1);
        check_eq("t4_key_c1", key_out, 0);
        @(negedge clk);
        check_eq("t4_busy_c2", busy, 0);
        wait_idle();
        check_drained("t4");
        cfg_default();

        // Zero durations treated as one
        dit_units = 0; ppu = 0;
        arm();
        send(DIT, 1);
        wait_idle();
        check_drained("t5");
        cfg_default();

        // Reset during a dah
        mon_en = 0;
        send(DAH, 0);
        sym_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_key_before_rst", key_out, 1);
        #2 rst_n = 0;
        #1;
        check_eq("t6_key_async", key_out, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_ready", sym_ready, 1);
        check_eq("t6_tone", tone_out, 0);
        @(negedge clk);
        rst_n = 1;
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (key_out) highs++;
        end
        check_eq("t6_residual_mark", highs, 0);
        check_eq("t6_busy_after", busy, 0);

        // Random stream with per-symbol timing
        arm();
        for (int i = 0; i < 14; i++) begin
            dit_units   = $urandom_range(0, 3);
            dah_units   = $urandom_range(0, 7);
            pause_units = $urandom_range(0, 3);
            char_units  = $urandom_range(0, 8);
            word_units  = $urandom_range(0, 12);
            ppu         = $urandom_range(0, 2);
            send(2'($urandom_range(0, 3)), 1);
        end
        wait_idle();
        check_drained("t7");
        cfg_default();

        check_eq("tone_while_key_low", tone_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
